pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
- Parametrised program sequencer; next-generation program counter for the core.
- Selects one of NUM_PROG programs by an explicit start command instead of counting resets.
- Supports relative conditional branches with a signed offset, plus CALL/RET through a hardware return stack, HALT, and stall.
- Drives instruction-memory address pc; sits between decode (op, boff) and the ALU flags (z, lt).

Parameters:
- PC_W, 8, program counter width; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 8, branch offset width, two's complement, sign-extended to PC_W.
- NUM_PROG, 3, number of selectable programs; PSEL_W = $clog2(NUM_PROG), minimum 1.
- RS_DEPTH, 4, return stack entries; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse: load the start address of prog_sel and run.
- prog_sel  in  PSEL_W  program index; sampled only with start.
- en  in  1  advance enable; 0 = stall, all state held.
- op  in  5  opcode; codes from package definitions.
- z  in  1  zero flag.
- lt  in  1  less-than flag.
- boff  in  OFF_W  signed relative branch/call offset.
- pc  out  PC_W  current instruction address.
- running  out  1  in RUN state.
- halted  out  1  in HALT state.
- fault  out  1  in FAULT state (stack over/underflow or bad prog_sel).
- rs_level  out  $clog2(RS_DEPTH)+1  return stack occupancy.

Behaviour:
- Reset (async, any time, including mid-run): pc=0, state=IDLE, stack emptied, rs_level=0, running=halted=fault=0.
- States: IDLE, RUN, HALT, FAULT. Outputs are registered decodes of state.
- IDLE: pc holds.
  - start with prog_sel<NUM_PROG: pc<=START_ADDR[prog_sel], go to RUN next edge.
  - prog_sel>=NUM_PROG: go to FAULT, pc unchanged.
- RUN, en=1, evaluated each edge. Taken target = pc + sext(boff), wraps mod 2^PC_W. Branch conditions:
  - BA: always taken.
  - BL: taken if lt.
  - BG: taken if !lt.
  - BE: taken if z.
  - Untaken branch: pc+1.
- CALL:
  - Push pc+1, pc<=target.
  - Stack full: FAULT, no push, pc holds.
- RET:
  - Pop into pc.
  - Stack empty: FAULT, pc holds.
- HALT: go to HALT, pc holds.
- Any other op: pc<=pc+1, wraps to 0.
- RUN, en=0: nothing changes, including stack and counters.
- start while in RUN: restart. Stack is flushed, pc<=START_ADDR[prog_sel] (same prog_sel check). start has priority over op.
- HALT and FAULT: pc frozen. start behaves as in IDLE (stack flushed). Otherwise stay until reset.
- Latency: pc updates on the edge after op is presented; no bypass. Branch resolution is combinational from op/z/lt in the same cycle.

Optional Feature:
- Macro PC_BRANCH_COUNT_EN.
- Defined: adds output br_count [15:0], counting taken BA/BL/BG/BE plus CALL/RET in RUN with en=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by a successful start.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package definitions:
  - Existing BA/BL/BG/BE codes.
  - New op codes CALL, RET, HALT.
  - pc_state_e enum (IDLE, RUN, HALT, FAULT).
  - START_ADDR localparam array (default 0, 25, 44).
- Sub-module pc_ret_stack (RS_DEPTH x PC_W LIFO):
  - Inputs push, pop, flush.
  - Outputs top, full, empty, level.
  - Same async reset.

Test Plan:
- Program select: reset, start with prog_sel=1 -> pc=25 next cycle, running=1; next edges with a non-branch op -> 26, 27.
- Branches: pc=10.
  - BE, z=1, boff=-3 -> pc=7.
  - BL, lt=0 -> pc=11.
  - BA, boff=5 at pc=252 -> pc=1 (wrap).
- Call/return: CALL at pc=30, boff=10 -> pc=40, rs_level=1; RET -> pc=31, rs_level=0. Nest 4 calls then a 5th CALL -> fault=1, pc held.
- Faults/stall:
  - RET with empty stack -> fault=1, pc held.
  - en=0 for 3 cycles with BA op -> pc and rs_level unchanged.
- Reset mid-run: assert reset between edges during RUN with rs_level=2 -> pc=0, rs_level=0, outputs low immediately. Then start with prog_sel=3 -> fault=1.
- PC_BRANCH_COUNT_EN defined: 3 taken and 2 untaken branches -> br_count=3; a successful start clears it to 0.

Source files
------------

// File: rtl/pc_seq_unit_pkg.sv
// Shared opcodes, sequencer states and per-program start addresses for pc_seq_unit.
package pc_seq_unit_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_BA   = 5'h01;
  localparam logic [4:0] OP_BL   = 5'h02;
  localparam logic [4:0] OP_BG   = 5'h03;
  localparam logic [4:0] OP_BE   = 5'h04;
  localparam logic [4:0] OP_CALL = 5'h05;
  localparam logic [4:0] OP_RET  = 5'h06;
  localparam logic [4:0] OP_HALT = 5'h07;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

  localparam int unsigned START_ADDR [0:2] = '{0, 25, 44};

  // Programs beyond the table get evenly spaced entry points.
  function automatic int unsigned start_addr(input int unsigned idx);
    case (idx)
      0:       return START_ADDR[0];
      1:       return START_ADDR[1];
      2:       return START_ADDR[2];
      default: return idx * 16;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_unit_ret_stack.sv
// Return-address LIFO for CALL/RET; push is ignored when full, pop when empty.
module pc_ret_stack #(
  parameter  int PC_W     = 8,
  parameter  int RS_DEPTH = 4,
  localparam int LVL_W    = $clog2(RS_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [PC_W-1:0]  din,
  output logic [PC_W-1:0]  top,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [PC_W-1:0]  mem [RS_DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign wr_idx  = level[IDX_W-1:0];
  assign top_idx = wr_idx - IDX_W'(1);
  assign top     = mem[top_idx];
  assign full    = (level == LVL_W'(RS_DEPTH));
  assign empty   = (level == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                level <= '0;
    else if (flush)           level <= '0;
    else if (push && !full)   level <= level + LVL_W'(1);
    else if (pop && !empty)   level <= level - LVL_W'(1);
  end

  // Storage needs no reset: entries above level are never read.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program sequencer: start-selected programs, relative branches, CALL/RET, HALT, stall.
// Optional br_count output (taken-branch/call/ret counter) under macro PC_BRANCH_COUNT_EN.
module pc_seq_unit
  import pc_seq_unit_pkg::*;
#(
  parameter  int PC_W     = 8,
  parameter  int OFF_W    = 8,
  parameter  int NUM_PROG = 3,
  parameter  int RS_DEPTH = 4,
  localparam int PSEL_W   = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1,
  localparam int LVL_W    = $clog2(RS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PSEL_W-1:0] prog_sel,
  input  logic              en,
  input  logic [4:0]        op,
  input  logic              z,
  input  logic              lt,
  input  logic [OFF_W-1:0]  boff,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              halted,
  output logic              fault,
  output logic [LVL_W-1:0]  rs_level
`ifdef PC_BRANCH_COUNT_EN
 ,output logic [15:0]       br_count
`endif
);
  localparam int EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_d, pc_inc, target, rs_top;
  logic [EXT_W-1:0] off_wide;
  logic            sel_ok, taken, is_branch;
  logic            push, pop, flush, rs_full, rs_empty;
  logic            cnt_inc, cnt_clr;

  assign off_wide = EXT_W'(signed'(boff));
  assign target   = pc + off_wide[PC_W-1:0];
  assign pc_inc   = pc + PC_W'(1);
  assign sel_ok   = (int'(prog_sel) < NUM_PROG);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (op)
      OP_BA:   taken = 1'b1;
      OP_BL:   taken = lt;
      OP_BG:   taken = !lt;
      OP_BE:   taken = z;
      default: is_branch = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    // start overrides any opcode and revives HALT/FAULT.
    if (start) begin
      flush = 1'b1;
      if (sel_ok) begin
        state_d = ST_RUN;
        pc_d    = PC_W'(start_addr(32'(prog_sel)));
        cnt_clr = 1'b1;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (state_q == ST_RUN && en) begin
      if (is_branch) begin
        pc_d    = taken ? target : pc_inc;
        cnt_inc = taken;
      end else begin
        case (op)
          OP_CALL: begin
            if (rs_full) state_d = ST_FAULT;
            else begin
              push    = 1'b1;
              pc_d    = target;
              cnt_inc = 1'b1;
            end
          end
          OP_RET: begin
            if (rs_empty) state_d = ST_FAULT;
            else begin
              pop     = 1'b1;
              pc_d    = rs_top;
              cnt_inc = 1'b1;
            end
          end
          OP_HALT: state_d = ST_HALT;
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc      <= '0;
      running <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      running <= (state_d == ST_RUN);
      halted  <= (state_d == ST_HALT);
      fault   <= (state_d == ST_FAULT);
    end
  end

  pc_ret_stack #(.PC_W(PC_W), .RS_DEPTH(RS_DEPTH)) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (pc_inc),
    .top   (rs_top),
    .full  (rs_full),
    .empty (rs_empty),
    .level (rs_level)
  );

`ifdef PC_BRANCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 br_count <= '0;
    else if (cnt_clr)                          br_count <= '0;
    else if (cnt_inc && br_count != 16'hFFFF)  br_count <= br_count + 16'd1;
  end
`else
  logic unused_cnt;
  assign unused_cnt = cnt_inc ^ cnt_clr;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed and randomized checks of pc_seq_unit against a queue-based reference model.
module tb_pc_seq_unit;
  localparam int OP_NOP = 0, OP_BA = 1, OP_BL = 2, OP_BG = 3, OP_BE = 4;
  localparam int OP_CALL = 5, OP_RET = 6, OP_HALT = 7;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, start, en, z, lt;
  logic [1:0] prog_sel;
  logic [4:0] op;
  logic [7:0] boff, pc;
  logic       running, halted, fault;
  logic [2:0] rs_level;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] br_count;
`endif

  pc_seq_unit #(.PC_W(8), .OFF_W(8), .NUM_PROG(3), .RS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .en(en),
    .op(op), .z(z), .lt(lt), .boff(boff), .pc(pc), .running(running),
    .halted(halted), .fault(fault), .rs_level(rs_level)
`ifdef PC_BRANCH_COUNT_EN
   ,.br_count(br_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: program counter as an integer, return stack as a queue.
  int m_pc, m_st, m_cnt;
  int m_stack[$];
  int prog_base[3] = '{0, 25, 44};

  task automatic model_reset();
    m_pc = 0; m_st = M_IDLE; m_cnt = 0;
    m_stack.delete();
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("rs_level", rs_level, m_stack.size());
    check("running", running, m_st == M_RUN);
    check("halted", halted, m_st == M_HALT);
    check("fault", fault, m_st == M_FAULT);
`ifdef PC_BRANCH_COUNT_EN
    check("br_count", br_count, m_cnt);
`endif
  endtask

  task automatic step(input bit st, input int sel, input bit e, input int o,
                      input bit zz, input bit ll, input int off);
    int  soff, tgt, nxt;
    bit  br, tk;
    start = st; prog_sel = 2'(sel); en = e; op = 5'(o); z = zz; lt = ll; boff = 8'(off);
    soff = (off >= 128) ? off - 256 : off;
    tgt  = ((m_pc + soff) % 256 + 256) % 256;
    nxt  = (m_pc + 1) % 256;
    br   = (o >= OP_BA && o <= OP_BE);
    tk   = (o == OP_BA) || (o == OP_BL && ll) || (o == OP_BG && !ll) || (o == OP_BE && zz);
    if (st) begin
      m_stack.delete();
      if (sel < 3) begin m_pc = prog_base[sel]; m_st = M_RUN; m_cnt = 0; end
      else m_st = M_FAULT;
    end else if (m_st == M_RUN && e) begin
      if (br) begin
        m_pc = tk ? tgt : nxt;
        if (tk && m_cnt < 65535) m_cnt++;
      end else if (o == OP_CALL) begin
        if (m_stack.size() == DEPTH) m_st = M_FAULT;
        else begin
          m_stack.push_back(nxt); m_pc = tgt;
          if (m_cnt < 65535) m_cnt++;
        end
      end else if (o == OP_RET) begin
        if (m_stack.size() == 0) m_st = M_FAULT;
        else begin
          m_pc = m_stack.pop_back();
          if (m_cnt < 65535) m_cnt++;
        end
      end else if (o == OP_HALT) m_st = M_HALT;
      else m_pc = nxt;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic run_op(input int o, input int off);
    step(0, 0, 1, o, 0, 0, off);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 0; prog_sel = 0; en = 0; op = 0; z = 0; lt = 0; boff = 0;
    model_reset();
    #12;
    check("rst_pc", pc, 0);
    check("rst_lvl", rs_level, 0);
    check("rst_flags", {running, halted, fault}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Program select
    step(1, 1, 1, OP_NOP, 0, 0, 0);
    check("sel1_pc", pc, 25);
    check("sel1_run", running, 1);
    run_op(OP_NOP, 0); check("seq_26", pc, 26);
    run_op(OP_NOP, 0); check("seq_27", pc, 27);

    // Branches
    step(1, 0, 1, OP_NOP, 0, 0, 0);
    repeat (10) run_op(OP_NOP, 0);
    check("at_10", pc, 10);
    step(0, 0, 1, OP_BE, 1, 0, 253); check("be_back3", pc, 7);
    run_op(OP_BA, 3);                check("ba_fwd3", pc, 10);
    step(0, 0, 1, OP_BL, 0, 0, 40);  check("bl_untaken", pc, 11);
    run_op(OP_BA, 241);              check("ba_to_252", pc, 252);
    run_op(OP_BA, 5);                check("ba_wrap", pc, 1);
    run_op(OP_BA, 29);               check("at_30", pc, 30);

    // Call / return
    run_op(OP_CALL, 10); check("call_pc", pc, 40); check("call_lvl", rs_level, 1);
    run_op(OP_RET, 0);   check("ret_pc", pc, 31);  check("ret_lvl", rs_level, 0);
    repeat (4) run_op(OP_CALL, 2);
    check("nest_lvl", rs_level, 4);
    run_op(OP_CALL, 2);
    check("ovf_fault", fault, 1);
    check("ovf_pc", pc, 39);

    // Underflow and stall
    step(1, 0, 1, OP_NOP, 0, 0, 0);
    check("restart_lvl", rs_level, 0);
    run_op(OP_RET, 0);
    check("unf_fault", fault, 1);
    check("unf_pc", pc, 0);
    step(1, 2, 1, OP_NOP, 0, 0, 0);
    check("sel2_pc", pc, 44);
    run_op(OP_CALL, 4);
    repeat (3) step(0, 0, 0, OP_BA, 0, 0, 5);
    check("stall_pc", pc, 48);
    check("stall_lvl", rs_level, 1);

    // Asynchronous reset mid-run with two return addresses stacked
    run_op(OP_CALL, 4);
    check("pre_rst_lvl", rs_level, 2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("arst_pc", pc, 0);
    check("arst_lvl", rs_level, 0);
    check("arst_flags", {running, halted, fault}, 0);
    #1 reset = 1'b0;
    step(1, 3, 1, OP_NOP, 0, 0, 0);
    check("badsel_fault", fault, 1);

`ifdef PC_BRANCH_COUNT_EN
    step(1, 0, 1, OP_NOP, 0, 0, 0);
    step(0, 0, 1, OP_BA, 0, 0, 1);
    step(0, 0, 1, OP_BL, 0, 1, 2);
    step(0, 0, 1, OP_BG, 0, 1, 2);
    step(0, 0, 1, OP_BE, 0, 0, 2);
    step(0, 0, 1, OP_BE, 1, 0, 2);
    check("brcnt_3", br_count, 3);
    step(1, 1, 1, OP_NOP, 0, 0, 0);
    check("brcnt_clr", br_count, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit st;
      int o;
      st = ($urandom_range(0, 39) == 0);
      o  = ($urandom_range(0, 19) == 0) ? 31 : int'($urandom_range(0, 9));
      if (o == OP_HALT && $urandom_range(0, 3) != 0) o = OP_NOP;
      step(st, int'($urandom_range(0, 3)), st ? 1'b1 : ($urandom_range(0, 4) != 0),
           o, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
